pll_reset_sequencer: RTL and testbench

Parametrised reset generator placed directly after a PLL wrapper. It takes the PLL's raw asynchronous lock flag and synchronises it. It then requires lock to stay high for a programmable qualification window before releasing several reset domains one after another, spaced a fixed number of cycles apart. On loss of lock or a soft-reset request it re-asserts all domain resets, and it records lock loss in a sticky flag for debug.

---
 rtl/pll_reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Reset generator placed after a PLL wrapper. Synchronises the raw lock
//   flag, qualifies it for LOCK_STABLE_CYCLES consecutive cycles, then
//   releases NUM_CHANNELS reset domains in index order, STAGGER_CYCLES apart.
//   Loss of lock or a soft reset re-asserts every domain reset; loss of lock
//   after release has started is recorded in a sticky debug flag.
//
// Ports
//   clock_in      PLL output clock, rising edge
//   rst_n         asynchronous active-low reset
//   pll_lock      raw PLL lock, asynchronous to clock_in
//   soft_reset    one-cycle request to re-run the release sequence
//   clear_sticky  clears lock_lost
//   rst_out       active-high domain resets, registered
//   all_released  high while every rst_out bit is 0, registered
//   lock_lost     sticky: lock dropped during RELEASE or RUN
//   state         0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN
module pll_reset_sequencer #(
   parameter int NUM_CHANNELS       = 4,
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGGER_CYCLES     = 16,
   parameter int CNT_W              = 16
) (
   input  logic                    clock_in,
   input  logic                    rst_n,
   input  logic                    pll_lock,
   input  logic                    soft_reset,
   input  logic                    clear_sticky,
   output logic [NUM_CHANNELS-1:0] rst_out,
   output logic                    all_released,
   output logic                    lock_lost,
   output logic [1:0]              state
);

   localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CHANNELS - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_sync;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       stag;
   logic [IDX_W-1:0]       idx;

   assign lock_sync = sync_q[SYNC_STAGES-1];
   assign state     = state_q;

   always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
      end
   end

   always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= WAIT_LOCK;
         cnt          <= '0;
         stag         <= '0;
         idx          <= '0;
         rst_out      <= '1;
         all_released <= 1'b0;
         lock_lost    <= 1'b0;
      end else begin
         // Clear first so a simultaneous set below takes precedence.
         if (clear_sticky) begin
            lock_lost <= 1'b0;
         end

         if (!lock_sync) begin
            if (state_q == RELEASE || state_q == RUN) begin
               lock_lost <= 1'b1;
            end
            state_q      <= WAIT_LOCK;
            cnt          <= '0;
            stag         <= '0;
            idx          <= '0;
            rst_out      <= '1;
            all_released <= 1'b0;
         end else if (soft_reset && (state_q == RELEASE || state_q == RUN)) begin
            state_q      <= RELEASE;
            stag         <= '0;
            idx          <= '0;
            rst_out      <= '1;
            all_released <= 1'b0;
         end else begin
            case (state_q)
               WAIT_LOCK: begin
                  state_q <= STABLE;
                  cnt     <= '0;
                  stag    <= '0;
                  idx     <= '0;
               end
               STABLE: begin
                  if (cnt == LOCK_LAST) begin
                     state_q <= RELEASE;
                     cnt     <= '0;
                     stag    <= '0;
                     idx     <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               RELEASE: begin
                  if (stag == STAG_LAST) begin
                     // Channels release strictly in index order, so the
                     // active-high reset vector simply shifts a 0 in at bit 0.
                     rst_out <= rst_out << 1;
                     stag    <= '0;
                     idx     <= idx + IDX_W'(1);
                     if (idx == IDX_LAST) begin
                        state_q      <= RUN;
                        idx          <= '0;
                        all_released <= 1'b1;
                     end
                  end else begin
                     stag <= stag + CNT_W'(1);
                  end
               end
               RUN: begin
               end
               default: begin
                  state_q <= WAIT_LOCK;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Scoreboard bench: the stimulus process advances a timing-level reference
//   model each edge and queues the expected outputs; a monitor process pops
//   and compares them against the DUT shortly after each edge or async reset.
module tb_pll_reset_sequencer;

   localparam int N  = 3;
   localparam int SS = 2;
   localparam int L  = 8;
   localparam int S  = 4;

   logic         clock_in = 1'b0;
   logic         rst_n = 1'b0;
   logic         pll_lock = 1'b0;
   logic         soft_reset = 1'b0;
   logic         clear_sticky = 1'b0;
   logic [N-1:0] rst_out;
   logic         all_released;
   logic         lock_lost;
   logic [1:0]   state;

   pll_reset_sequencer #(
      .NUM_CHANNELS      (N),
      .SYNC_STAGES       (SS),
      .LOCK_STABLE_CYCLES(L),
      .STAGGER_CYCLES    (S),
      .CNT_W             (16)
   ) dut (
      .clock_in    (clock_in),
      .rst_n       (rst_n),
      .pll_lock    (pll_lock),
      .soft_reset  (soft_reset),
      .clear_sticky(clear_sticky),
      .rst_out     (rst_out),
      .all_released(all_released),
      .lock_lost   (lock_lost),
      .state       (state)
   );

   always #5 clock_in = ~clock_in;

   typedef struct packed {
      logic [N-1:0] rst;
      logic         all;
      logic         ll;
      logic [1:0]   st;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: lock seen by the sequencer is pll_lock from SS edges
   // earlier; release timing is derived from the edge the release phase began.
   int lockq[$];
   int q_run;       // consecutive qualified-lock edges while not releasing
   bit active;      // release phase entered (RELEASE or RUN)
   int rel_base;    // edge number at which release phase (re)started
   int n_edge;
   bit ll_m;

   function automatic exp_t expected_now();
      exp_t e;
      int   rel;
      e.rst = '1;
      e.all = 1'b0;
      e.ll  = ll_m;
      if (active) begin
         rel = (n_edge - rel_base) / S;
         if (rel > N) rel = N;
         for (int k = 0; k < rel; k++) e.rst[k] = 1'b0;
         e.all = (rel == N);
         e.st  = e.all ? 2'd3 : 2'd2;
      end else begin
         e.st = (q_run == 0) ? 2'd0 : 2'd1;
      end
      return e;
   endfunction

   task automatic model_reset();
      lockq.delete();
      for (int i = 0; i < SS; i++) lockq.push_back(0);
      q_run  = 0;
      active = 1'b0;
      ll_m   = 1'b0;
      sbq.push_back(expected_now());
   endtask

   task automatic model_edge();
      int ls;
      bit set_ll;
      if (!rst_n) begin
         model_reset();
         return;
      end
      n_edge++;
      ls = lockq.pop_front();
      lockq.push_back(int'(pll_lock));
      set_ll = 1'b0;
      if (ls == 0) begin
         if (active) set_ll = 1'b1;
         active = 1'b0;
         q_run  = 0;
      end else if (active) begin
         if (soft_reset) rel_base = n_edge;
      end else begin
         q_run++;
         if (q_run == L + 1) begin
            active   = 1'b1;
            rel_base = n_edge;
         end
      end
      if (clear_sticky) ll_m = 1'b0;
      if (set_ll) ll_m = 1'b1;
      sbq.push_back(expected_now());
   endtask

   // Called at a falling clock edge; returns at the next falling edge.
   task automatic step(input bit lk, input bit sr, input bit cs);
      pll_lock     = lk;
      soft_reset   = sr;
      clear_sticky = cs;
      @(posedge clock_in);
      model_edge();
      @(negedge clock_in);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      forever begin
         exp_t e;
         @(posedge clock_in or negedge rst_n);
         #1;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if (rst_out !== e.rst || all_released !== e.all ||
                lock_lost !== e.ll || state !== e.st) begin
               fails++;
               $display("FAIL outputs t=%0t: got rst_out=%b all_released=%b lock_lost=%b state=%0d, want rst_out=%b all_released=%b lock_lost=%b state=%0d",
                        $time, rst_out, all_released, lock_lost, state,
                        e.rst, e.all, e.ll, e.st);
            end
         end
      end
   end

   initial begin
      bit lv;
      n_edge = 0;
      rel_base = 0;
      model_reset();
      @(negedge clock_in);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // nominal power-up
      repeat (30) step(1'b1, 1'b0, 1'b0);
      // soft reset in RUN
      step(1'b1, 1'b1, 1'b0);
      repeat (16) step(1'b1, 1'b0, 1'b0);
      // lock loss in RUN, relock, clear sticky
      repeat (4) step(1'b0, 1'b0, 1'b0);
      repeat (30) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      // lock glitch during qualification
      apply_reset();
      repeat (5) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      repeat (30) step(1'b1, 1'b0, 1'b0);
      // soft reset on the same edge as the lock drop reaching the FSM
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      // back to RUN, clear, then clear on the same edge as a lock drop
      repeat (30) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      // async reset mid-RELEASE, then nominal timing again
      repeat (17) step(1'b1, 1'b0, 1'b0);
      apply_reset();
      repeat (30) step(1'b1, 1'b0, 1'b0);

      // randomized traffic: long lock runs with short drops
      lv = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         if (lv ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 2) == 0))
            lv = !lv;
         if ($urandom_range(0, 799) == 0) apply_reset();
         step(lv, ($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0));
      end

      repeat (3) @(negedge clock_in);
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
